sec_min_timebase: RTL and testbench
===================================

Name: sec_min_timebase

Overview:
- Upstream stage of the hour counter in the digital clock.
- Divides the system clock to a 1 Hz tick and keeps BCD seconds and minutes, each mod 60.
- Emits a one-cycle hour_en pulse that drives the hour counter's enable input.
- Hosts the time-set FSM: user buttons step hours (through hour_en) or minutes without carry.

Parameters:
TICK_DIV, 50000000, system clocks per second tick; legal range >= 2; prescaler width = clog2(TICK_DIV)

Ports:
clk  input  1  system clock; all logic on rising edge
rstn  input  1  synchronous active-low reset, sampled on rising edge of clk
run  input  1  1 = timekeeping enabled; 0 = prescaler and sec/min hold (set FSM still active)
mode_btn  input  1  single-cycle pulse (debounced upstream); advances set FSM
inc_btn  input  1  single-cycle pulse; increments selected field in set states
secH  output  4  seconds tens, BCD 0-5
secL  output  4  seconds units, BCD 0-9
minH  output  4  minutes tens, BCD 0-5
minL  output  4  minutes units, BCD 0-9
hour_en  output  1  registered one-cycle pulse to hour counter enable
sec_tick  output  1  registered one-cycle pulse per second (RUN only)
set_state  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 unused

Behaviour:
- Reset (rstn=0 at an edge): secH/secL/minH/minL=0, hour_en=0, sec_tick=0, prescaler=0, set_state=RUN. Reset overrides all inputs, including mid-set.
- Prescaler: counts 0..TICK_DIV-1 only when state==RUN and run=1; otherwise holds its value. At TICK_DIV-1 it wraps to 0 and the tick fires.
- Tick timing: sec_tick is high in the cycle after the wrap edge. Seconds update on the same edge that sets sec_tick.
- Seconds update: secL+1. At secL==9: secL=0, secH+1. At 59: seconds=00 and minutes carry (+1 on the same edge).
- Minute update: same mod-60 rule. Carry from 59 to 00 occurs only when seconds also wrap.
- hour_en in RUN: registered; high for exactly one cycle after the edge on which {min,sec} go 59:59 -> 00:00. The hour counter samples it on the following edge.
- Illegal field values (units >9 or tens >5): any update of that field loads 00 and produces no carry.
- FSM transitions on mode_btn: RUN -> SET_HOUR -> SET_MIN -> RUN.
- SET_HOUR: inc_btn yields hour_en high for one cycle (next cycle). Seconds and minutes are untouched.
- SET_MIN: inc_btn increments minutes mod 60 with no hour_en, including at 59 -> 00.
- Leaving SET_MIN -> RUN: seconds=00 and prescaler=0 on the same edge, so the first tick arrives TICK_DIV cycles later.
- Entering SET_HOUR from RUN: any pending tick is suppressed; prescaler holds.
- inc_btn in RUN is ignored.
- mode_btn and inc_btn in the same cycle: mode wins; inc is dropped.
- hour_en can never double-pulse: in set states ticks are impossible; in RUN inc is ignored.
- set_state is registered and reflects the FSM state after each edge.

Optional Feature:
- Macro: SEC_MIN_TIMEBASE_BLINK_EN.
- Defined:
  - adds output blink (1 bit), which toggles every TICK_DIV/2 cycles in SET_HOUR and SET_MIN using a dedicated half-period counter.
  - blink=1 on entry to a set state; blink=0 in RUN and at reset.
  - display logic ANDs blink with the selected digit-enable.
- Undefined: blink port and its counter are absent; all other behaviour is identical.

Test Plan:
- rstn=0 for 1 edge, with random prior state and inputs toggling -> all digits 0, hour_en=0, sec_tick=0, set_state=00 after that edge.
- TICK_DIV=4, run=1, 40 cycles -> sec_tick every 4th cycle; secH=1, secL=0 after the 10th tick; run=0 for 20 cycles -> values and tick phase frozen.
- Preload 59:58 via SET_MIN and ticks -> second tick gives 00:00 and exactly one hour_en pulse in the following cycle; minutes 59 -> 00 wrap is checked.
- mode_btn -> set_state=01; inc_btn x3 (spaced) -> 3 isolated hour_en pulses, min/sec unchanged. mode_btn -> 10; inc at min=59 -> 00, no hour_en. mode_btn -> 00 with sec=00, next tick after 4 cycles.
- mode_btn and inc_btn together in SET_HOUR -> moves to SET_MIN, no hour_en; inc_btn alone in RUN -> no change.
- rstn=0 while in SET_MIN with min=37 -> state RUN, all zeros; with BLINK_EN, blink toggles every 2 cycles in set states and is 0 after reset.

Source files
------------

// File: rtl/sec_min_timebase.sv
// Seconds/minutes timebase for the digital clock: 1 Hz prescaler, BCD mod-60 fields,
// hour_en pulse and time-set FSM. Optional blink output when SEC_MIN_TIMEBASE_BLINK_EN is defined.
module sec_min_timebase #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] secH,
  output logic [3:0] secL,
  output logic [3:0] minH,
  output logic [3:0] minL,
  output logic       hour_en,
  output logic       sec_tick,
  output logic [1:0] set_state
`ifdef SEC_MIN_TIMEBASE_BLINK_EN
  ,
  output logic       blink
`endif
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0] sech_q, sech_d, secl_q, secl_d;
  logic [3:0] minh_q, minh_d, minl_q, minl_d;
  logic       hour_en_q, hour_en_d;
  logic       sec_tick_q, sec_tick_d;
  logic       sec_carry_s, min_carry_s;

  // Mod-60 BCD increment returning {carry, tens, units}; an illegal field reloads 00 without carry.
  function automatic logic [8:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] units);
    logic [8:0] res;
    if ((units > 4'd9) || (tens > 4'd5)) begin
      res = {1'b0, 4'd0, 4'd0};
    end else if (units == 4'd9) begin
      if (tens == 4'd5) begin
        res = {1'b1, 4'd0, 4'd0};
      end else begin
        res = {1'b0, tens + 4'd1, 4'd0};
      end
    end else begin
      res = {1'b0, tens, units + 4'd1};
    end
    return res;
  endfunction

  // Next-state logic for FSM, prescaler, time fields and pulses.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    sech_d      = sech_q;
    secl_d      = secl_q;
    minh_d      = minh_q;
    minl_d      = minl_q;
    hour_en_d   = 1'b0;
    sec_tick_d  = 1'b0;
    sec_carry_s = 1'b0;
    min_carry_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        // mode_btn takes priority so a tick due this cycle is dropped on entering SET_HOUR
        if (mode_btn) begin
          state_d = ST_SET_HOUR;
        end else if (run) begin
          if (presc_q == PRESC_MAX) begin
            presc_d    = PRESC_ZERO;
            sec_tick_d = 1'b1;
            {sec_carry_s, sech_d, secl_d} = bcd60_inc(sech_q, secl_q);
            if (sec_carry_s) begin
              {min_carry_s, minh_d, minl_d} = bcd60_inc(minh_q, minl_q);
              hour_en_d = min_carry_s;
            end else begin
              hour_en_d = 1'b0;
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end else begin
          presc_d = presc_q;
        end
      end
      ST_SET_HOUR: begin
        if (mode_btn) begin
          state_d = ST_SET_MIN;
        end else if (inc_btn) begin
          hour_en_d = 1'b1;
        end else begin
          hour_en_d = 1'b0;
        end
      end
      ST_SET_MIN: begin
        if (mode_btn) begin
          state_d = ST_RUN;
          sech_d  = 4'd0;
          secl_d  = 4'd0;
          presc_d = PRESC_ZERO;
        end else if (inc_btn) begin
          {min_carry_s, minh_d, minl_d} = bcd60_inc(minh_q, minl_q);
        end else begin
          min_carry_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      presc_q    <= PRESC_ZERO;
      sech_q     <= 4'd0;
      secl_q     <= 4'd0;
      minh_q     <= 4'd0;
      minl_q     <= 4'd0;
      hour_en_q  <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sech_q     <= sech_d;
      secl_q     <= secl_d;
      minh_q     <= minh_d;
      minl_q     <= minl_d;
      hour_en_q  <= hour_en_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign secH      = sech_q;
  assign secL      = secl_q;
  assign minH      = minh_q;
  assign minL      = minl_q;
  assign hour_en   = hour_en_q;
  assign sec_tick  = sec_tick_q;
  assign set_state = state_q;

`ifdef SEC_MIN_TIMEBASE_BLINK_EN
  localparam logic [PW-1:0] HALF_MAX = PW'((TICK_DIV / 2) - 1);
  logic          blink_q, blink_d;
  logic [PW-1:0] bcnt_q, bcnt_d;

  // Blink restarts high on every entry into a set state and toggles each half tick period.
  always_comb begin
    blink_d = 1'b0;
    bcnt_d  = PRESC_ZERO;
    if (state_d == ST_RUN) begin
      blink_d = 1'b0;
      bcnt_d  = PRESC_ZERO;
    end else if (state_d != state_q) begin
      blink_d = 1'b1;
      bcnt_d  = PRESC_ZERO;
    end else if (bcnt_q == HALF_MAX) begin
      blink_d = ~blink_q;
      bcnt_d  = PRESC_ZERO;
    end else begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q + PRESC_ONE;
    end
  end

  // Blink registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      blink_q <= 1'b0;
      bcnt_q  <= PRESC_ZERO;
    end else begin
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign blink = blink_q;
`endif

endmodule

// File: tb/tb_sec_min_timebase.sv
// Self-checking bench for sec_min_timebase (TICK_DIV=4): an integer reference model pushes
// expected outputs to a scoreboard queue each cycle; they are popped and asserted after the edge.
module tb_sec_min_timebase;

  logic       clk = 1'b0;
  logic       rstn, run, mode_btn, inc_btn;
  logic [3:0] secH, secL, minH, minL;
  logic       hour_en, sec_tick;
  logic [1:0] set_state;
`ifdef SEC_MIN_TIMEBASE_BLINK_EN
  logic       blink;
`endif

  sec_min_timebase #(.TICK_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .run(run), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .secH(secH), .secL(secL), .minH(minH), .minL(minL),
    .hour_en(hour_en), .sec_tick(sec_tick), .set_state(set_state)
`ifdef SEC_MIN_TIMEBASE_BLINK_EN
    , .blink(blink)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sh, sl, mh, ml;
    logic       he, st;
    logic [1:0] ss;
    logic       bl;
  } exp_t;

  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int he_cnt   = 0;

  int m_state = 0, m_presc = 0, m_sec = 0, m_min = 0, m_bcnt = 0;
  logic m_he = 1'b0, m_st = 1'b0, m_blink = 1'b0;

  task automatic model_step();
    int ns;
    ns   = m_state;
    m_he = 1'b0;
    m_st = 1'b0;
    if (!rstn) begin
      ns = 0; m_presc = 0; m_sec = 0; m_min = 0; m_blink = 1'b0; m_bcnt = 0;
    end else begin
      case (m_state)
        0: begin
          if (mode_btn) ns = 1;
          else if (run) begin
            if (m_presc == 3) begin
              m_presc = 0;
              m_st    = 1'b1;
              m_sec   = m_sec + 1;
              if (m_sec == 60) begin
                m_sec = 0;
                m_min = m_min + 1;
                if (m_min == 60) begin
                  m_min = 0;
                  m_he  = 1'b1;
                end
              end
            end else m_presc = m_presc + 1;
          end
        end
        1: begin
          if (mode_btn) ns = 2;
          else if (inc_btn) m_he = 1'b1;
        end
        2: begin
          if (mode_btn) begin
            ns = 0; m_sec = 0; m_presc = 0;
          end else if (inc_btn) m_min = (m_min + 1) % 60;
        end
        default: ns = 0;
      endcase
      if (ns == 0) begin
        m_blink = 1'b0; m_bcnt = 0;
      end else if (ns != m_state) begin
        m_blink = 1'b1; m_bcnt = 0;
      end else if (m_bcnt == 1) begin
        m_blink = ~m_blink; m_bcnt = 0;
      end else m_bcnt = m_bcnt + 1;
    end
    m_state = ns;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.sh = 4'(m_sec / 10);
    e.sl = 4'(m_sec % 10);
    e.mh = 4'(m_min / 10);
    e.ml = 4'(m_min % 10);
    e.he = m_he;
    e.st = m_st;
    e.ss = 2'(m_state);
`ifdef SEC_MIN_TIMEBASE_BLINK_EN
    e.bl = m_blink;
`else
    e.bl = 1'b0;
`endif
    return e;
  endfunction

  task automatic cyc(input logic mb, input logic ib, input string tag);
    exp_t e, o;
    mode_btn = mb;
    inc_btn  = ib;
    model_step();
    exp_q.push_back(model_exp());
    @(posedge clk);
    #1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    o = '{sh: secH, sl: secL, mh: minH, ml: minL, he: hour_en, st: sec_tick, ss: set_state, bl: 1'b0};
`ifdef SEC_MIN_TIMEBASE_BLINK_EN
    o.bl = blink;
`endif
    if (hour_en === 1'b1) he_cnt++;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    rstn = 1'b0; run = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    cyc(1'b0, 1'b0, "reset_first");

    // random prior state, then a single reset edge with inputs toggling
    rstn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      run = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "random_prior");
    end
    rstn = 1'b0;
    run  = 1'($urandom_range(0, 1));
    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset_mid");
    check("reset_digits", {16'h0, minH, minL, secH, secL}, 32'h0);
    check("reset_flags", {28'h0, hour_en, sec_tick, set_state}, 32'h0);

    // free running: ten ticks in 40 cycles, then frozen with run=0
    rstn = 1'b1; run = 1'b1;
    repeat (40) cyc(1'b0, 1'b0, "run40");
    check("sec_after_10_ticks", {24'h0, secH, secL}, 32'h10);
    run = 1'b0;
    repeat (20) cyc(1'b0, 1'b0, "run_hold");
    check("sec_frozen", {24'h0, secH, secL}, 32'h10);
    run = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, "resume_phase");
    check("resume_no_tick_yet", {31'h0, sec_tick}, 32'h0);
    cyc(1'b0, 1'b0, "resume_tick");
    check("resume_tick", {24'h0, secH, secL}, 32'h11);

    // preload 59:58 then roll over the hour
    cyc(1'b1, 1'b0, "to_set_hour");
    cyc(1'b1, 1'b0, "to_set_min");
    repeat (59) cyc(1'b0, 1'b1, "min_preload");
    cyc(1'b1, 1'b0, "to_run");
    repeat (58 * 4) cyc(1'b0, 1'b0, "count_to_58");
    check("preload_5958", {16'h0, minH, minL, secH, secL}, 32'h5958);
    he_cnt = 0;
    repeat (10) cyc(1'b0, 1'b0, "hour_rollover");
    check("rollover_0000", {16'h0, minH, minL, secH, secL}, 32'h0000);
    check("rollover_one_hour_en", 32'(he_cnt), 32'd1);

    // SET_HOUR: three spaced inc presses give three hour_en pulses
    cyc(1'b1, 1'b0, "enter_set_hour");
    check("state_set_hour", {30'h0, set_state}, 32'h1);
    he_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, "hour_inc");
      cyc(1'b0, 1'b0, "hour_gap");
      cyc(1'b0, 1'b0, "hour_gap");
    end
    check("three_hour_pulses", 32'(he_cnt), 32'd3);

    // SET_MIN: wrap 59 -> 00 without hour_en
    cyc(1'b1, 1'b0, "enter_set_min");
    check("state_set_min", {30'h0, set_state}, 32'h2);
    he_cnt = 0;
    repeat (59) cyc(1'b0, 1'b1, "min_inc");
    check("min_at_59", {24'h0, minH, minL}, 32'h59);
    cyc(1'b0, 1'b1, "min_wrap");
    check("min_wrap_00", {24'h0, minH, minL}, 32'h00);
    check("set_min_no_hour_en", 32'(he_cnt), 32'd0);

    // back to RUN: seconds cleared, first tick TICK_DIV cycles later
    cyc(1'b1, 1'b0, "exit_to_run");
    check("exit_sec_zero", {22'h0, set_state, secH, secL}, 32'h0);
    repeat (3) cyc(1'b0, 1'b0, "first_tick_wait");
    check("no_early_tick", {31'h0, sec_tick}, 32'h0);
    cyc(1'b0, 1'b0, "first_tick");
    check("first_tick", {27'h0, sec_tick, secL}, 32'h11);

    // mode+inc together in SET_HOUR; inc alone in RUN
    cyc(1'b1, 1'b0, "enter_set_hour2");
    he_cnt = 0;
    cyc(1'b1, 1'b1, "mode_and_inc");
    check("mode_wins_state", {30'h0, set_state}, 32'h2);
    check("mode_wins_no_hour", 32'(he_cnt), 32'd0);
    cyc(1'b1, 1'b0, "exit_to_run2");
    cyc(1'b0, 1'b1, "inc_in_run");
    cyc(1'b0, 1'b1, "inc_in_run");
    check("inc_run_minutes", {24'h0, minH, minL}, 32'h00);

    // reset while in SET_MIN at 37
    cyc(1'b1, 1'b0, "enter_set_hour3");
    cyc(1'b1, 1'b0, "enter_set_min3");
    while (m_min != 37) cyc(1'b0, 1'b1, "min_to_37");
    check("min_is_37", {24'h0, minH, minL}, 32'h37);
    rstn = 1'b0;
    cyc(1'b1, 1'b1, "reset_in_set_min");
    check("reset_set_min_all", {14'h0, set_state, minH, minL, secH, secL}, 32'h0);
    rstn = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, "post_reset");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
